spi_mosi_burst_buffer: RTL
==========================

Name: spi_mosi_burst_buffer

Overview:
Parametrised successor to the N-byte MOSI buffer in the SSD1331 OLED SPI path. Captures up to N bytes with per-byte D/C flags and sends a runtime-selectable count (i_LEN) to the SPI serialiser, one byte every WIDTH clocks. Provides a ready/done handshake, chip-select framing and gap-free chaining of bursts. Sits between the OLED command/pixel sequencer and the bit-level MOSI shifter.

Parameters:
WIDTH, 8, bits per byte presented to the serialiser
N, 16, maximum bytes per burst
CNT_W, $clog2(N+1), width of length and index fields

Ports:
i_SCK  in  1  clock; all logic on rising edge
i_RST  in  1  reset, synchronous, active-low
i_DATA  in  WIDTH*N  burst payload; byte k = i_DATA[k*WIDTH +: WIDTH], byte 0 sent first
i_DC  in  N  D/C flag per byte; bit k goes with byte k
i_LEN  in  CNT_W  bytes to send, 1..N
i_START  in  1  burst request; accepted only when o_READY=1
o_READY  out  1  combinational; burst may be accepted this cycle
o_DATA  out  WIDTH  byte currently presented to serialiser
o_DC  out  1  D/C flag for o_DATA
o_START  out  1  level; high while serialiser must shift
o_CS_N  out  1  OLED chip select, active-low
o_BYTE_IDX  out  CNT_W  index of byte on o_DATA
o_FINAL_BYTE  out  1  high for all WIDTH cycles of the last byte
o_DONE  out  1  one-cycle pulse after the last bit of a burst not followed by a chained burst

Behaviour:
- States IDLE, SEND. Internal: data reg, DC reg, length reg, bit counter 0..WIDTH-1, byte index.
- Reset (i_RST=0 at a rising edge): state IDLE, o_DATA=0, o_DC=0, o_START=0, o_CS_N=1, o_BYTE_IDX=0, o_FINAL_BYTE=0, o_DONE=0, counters 0. Reset mid-burst aborts immediately; no o_DONE.
- o_READY = (state==IDLE) OR (state==SEND AND bit==WIDTH-1 AND byte_idx==len-1).
- Accept = i_START AND o_READY AND i_LEN!=0. i_LEN=0: request ignored, no state or output change. i_LEN>N: clamped to N.
- On accept (edge T): capture i_DATA, i_DC, length. At T: o_DATA=byte0, o_DC=i_DC[0], o_START=1, o_CS_N=0, o_BYTE_IDX=0, bit=0, o_FINAL_BYTE=(len==1); state SEND. One-cycle latency from request to first byte.
- SEND: bit increments every cycle. At bit==WIDTH-1 with byte_idx<len-1: next edge presents byte_idx+1 and its DC, bit=0, o_FINAL_BYTE=(byte_idx+1==len-1).
- Last bit of last byte with accept: new burst loads as above, no idle cycle; o_START and o_CS_N unchanged; no o_DONE.
- Last bit of last byte without accept: next edge state IDLE, o_START=0, o_CS_N=1, o_FINAL_BYTE=0, o_DONE=1 for one cycle; o_DATA/o_DC hold last value.
- i_START while busy (o_READY=0): ignored, not queued.
- Bytes per burst = len; cycles per burst = len*WIDTH exactly.

Optional Feature:
Macro SPI_MOSI_BURST_ABORT_EN. When defined: adds input i_ABORT (1 bit) and output o_ABORTED (1 bit, reset 0). i_ABORT high in SEND sets a sticky flag; the current byte completes its WIDTH cycles, no further bytes are presented, a chain request in that final cycle is refused (o_READY=0), then state IDLE, o_CS_N=1, o_ABORTED=1 for one cycle, o_DONE stays 0. i_ABORT in IDLE is ignored. When not defined: ports absent, behaviour as above.

Test Plan:
- Reset: hold i_RST=0 for 3 cycles with i_START=1 -> o_CS_N=1, o_START=0, o_READY=1, all other outputs 0.
- WIDTH=8, i_LEN=3, bytes 0xA0,0x15,0x3F, i_DC=3'b100 -> o_DATA sequence 0xA0/0x15/0x3F, 8 cycles each, o_DC 0,0,1; o_FINAL_BYTE high cycles 17-24; o_DONE pulse at cycle 25; o_CS_N low exactly 24 cycles.
- i_LEN=0 with i_START=1 -> no state change, o_START stays 0; i_LEN=20 (N=16) -> 16 bytes, 128 cycles.
- Chain: burst len=2, i_START=1 with new len=1 byte 0x5A in final bit cycle -> 0x5A follows without gap, o_START/o_CS_N continuous, single o_DONE after 0x5A.
- i_START pulsed mid-burst and i_RST=0 at byte 1 bit 4 of a len=4 burst -> first ignored; reset returns to IDLE next edge, no o_DONE.
- With SPI_MOSI_BURST_ABORT_EN: len=4, i_ABORT at byte 1 bit 2 -> byte 1 completes, byte 2 never presented, o_ABORTED pulse, o_DONE=0.

Source files
------------

// File: rtl/spi_mosi_burst_buffer_if.sv
// Sequencer-to-burst-buffer bus for the SSD1331 MOSI path.
// The abort signals exist only when SPI_MOSI_BURST_ABORT_EN is defined.
interface spi_mosi_burst_buffer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = $clog2(N + 1)
);

  logic [WIDTH*N-1:0] i_DATA;
  logic [N-1:0]       i_DC;
  logic [CNT_W-1:0]   i_LEN;
  logic               i_START;
  logic               o_READY;
  logic [WIDTH-1:0]   o_DATA;
  logic               o_DC;
  logic               o_START;
  logic               o_CS_N;
  logic [CNT_W-1:0]   o_BYTE_IDX;
  logic               o_FINAL_BYTE;
  logic               o_DONE;
`ifdef SPI_MOSI_BURST_ABORT_EN
  logic               i_ABORT;
  logic               o_ABORTED;
`endif

`ifdef SPI_MOSI_BURST_ABORT_EN
  modport master (
    output i_DATA, i_DC, i_LEN, i_START, i_ABORT,
    input  o_READY, o_DATA, o_DC, o_START, o_CS_N, o_BYTE_IDX,
           o_FINAL_BYTE, o_DONE, o_ABORTED
  );

  modport slave (
    input  i_DATA, i_DC, i_LEN, i_START, i_ABORT,
    output o_READY, o_DATA, o_DC, o_START, o_CS_N, o_BYTE_IDX,
           o_FINAL_BYTE, o_DONE, o_ABORTED
  );
`else
  modport master (
    output i_DATA, i_DC, i_LEN, i_START,
    input  o_READY, o_DATA, o_DC, o_START, o_CS_N, o_BYTE_IDX,
           o_FINAL_BYTE, o_DONE
  );

  modport slave (
    input  i_DATA, i_DC, i_LEN, i_START,
    output o_READY, o_DATA, o_DC, o_START, o_CS_N, o_BYTE_IDX,
           o_FINAL_BYTE, o_DONE
  );
`endif

endinterface

// File: rtl/spi_mosi_burst_buffer.sv
// N-byte MOSI burst buffer: presents up to N bytes (one per WIDTH clocks) with D/C,
// CS framing and gap-free chaining. Optional abort via SPI_MOSI_BURST_ABORT_EN.
module spi_mosi_burst_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = $clog2(N + 1)
) (
  input  logic                  i_SCK,
  input  logic                  i_RST,
  spi_mosi_burst_buffer_if.slave bus
);

  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DATA_W = WIDTH * N;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_data;
  logic [N-1:0]       r_dc;
  logic [CNT_W-1:0]   r_len;
  logic [BIT_W-1:0]   r_bit;

  logic               w_last_bit;
  logic               w_last_byte;
  logic               w_burst_end;
  logic               w_abort;
  logic               w_accept;
  logic [CNT_W-1:0]   w_len_clamp;
  logic [CNT_W-1:0]   w_next_idx;

  assign w_last_bit  = (r_bit == BIT_W'(WIDTH - 1));
  assign w_last_byte = (bus.o_BYTE_IDX == (r_len - CNT_W'(1)));
  assign w_burst_end = (r_state == ST_SEND) && w_last_bit && w_last_byte;
  assign w_next_idx  = bus.o_BYTE_IDX + CNT_W'(1);

`ifdef SPI_MOSI_BURST_ABORT_EN
  logic r_abort_pend;

  // Abort is seen in the cycle it arrives so a chain request in that cycle is refused.
  assign w_abort = (r_state == ST_SEND) && (r_abort_pend || bus.i_ABORT);
`else
  assign w_abort = 1'b0;
`endif

  assign bus.o_READY = (r_state == ST_IDLE) || (w_burst_end && !w_abort);

  assign w_len_clamp = (bus.i_LEN > CNT_W'(N)) ? CNT_W'(N) : bus.i_LEN;
  assign w_accept    = bus.i_START && bus.o_READY && (bus.i_LEN != '0);

  // Remaining bytes live in a shift register; byte 0 goes straight to o_DATA on accept.
  always_ff @(posedge i_SCK) begin
    if (!i_RST) begin
      r_state          <= ST_IDLE;
      r_data           <= '0;
      r_dc             <= '0;
      r_len            <= '0;
      r_bit            <= '0;
      bus.o_DATA       <= '0;
      bus.o_DC         <= 1'b0;
      bus.o_START      <= 1'b0;
      bus.o_CS_N       <= 1'b1;
      bus.o_BYTE_IDX   <= '0;
      bus.o_FINAL_BYTE <= 1'b0;
      bus.o_DONE       <= 1'b0;
`ifdef SPI_MOSI_BURST_ABORT_EN
      r_abort_pend     <= 1'b0;
      bus.o_ABORTED    <= 1'b0;
`endif
    end else begin
      bus.o_DONE <= 1'b0;
`ifdef SPI_MOSI_BURST_ABORT_EN
      bus.o_ABORTED <= 1'b0;
`endif
      if (w_accept) begin
        r_state          <= ST_SEND;
        r_data           <= bus.i_DATA >> WIDTH;
        r_dc             <= bus.i_DC >> 1;
        r_len            <= w_len_clamp;
        r_bit            <= '0;
        bus.o_DATA       <= bus.i_DATA[WIDTH-1:0];
        bus.o_DC         <= bus.i_DC[0];
        bus.o_START      <= 1'b1;
        bus.o_CS_N       <= 1'b0;
        bus.o_BYTE_IDX   <= '0;
        bus.o_FINAL_BYTE <= (w_len_clamp == CNT_W'(1));
`ifdef SPI_MOSI_BURST_ABORT_EN
        r_abort_pend     <= 1'b0;
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_bit <= '0;
          end
          ST_SEND: begin
`ifdef SPI_MOSI_BURST_ABORT_EN
            if (bus.i_ABORT) begin
              r_abort_pend <= 1'b1;
            end
`endif
            if (!w_last_bit) begin
              r_bit <= r_bit + BIT_W'(1);
            end else if (!w_last_byte && !w_abort) begin
              r_bit            <= '0;
              r_data           <= r_data >> WIDTH;
              r_dc             <= r_dc >> 1;
              bus.o_DATA       <= r_data[WIDTH-1:0];
              bus.o_DC         <= r_dc[0];
              bus.o_BYTE_IDX   <= w_next_idx;
              bus.o_FINAL_BYTE <= (w_next_idx == (r_len - CNT_W'(1)));
            end else begin
              // End of burst (normal or aborted); o_DATA/o_DC keep the last byte.
              r_state          <= ST_IDLE;
              r_bit            <= '0;
              bus.o_START      <= 1'b0;
              bus.o_CS_N       <= 1'b1;
              bus.o_FINAL_BYTE <= 1'b0;
`ifdef SPI_MOSI_BURST_ABORT_EN
              r_abort_pend     <= 1'b0;
              bus.o_ABORTED    <= w_abort;
              bus.o_DONE       <= !w_abort;
`else
              bus.o_DONE       <= 1'b1;
`endif
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
